// File: rtl/id_ex_dm_datapath.sv
// Decode / execute / data-memory slice of a single-cycle MIPS-style datapath:
// register file, immediate/jump extraction, ALU with B-operand mux, word-addressed data memory.
module id_ex_dm_datapath #(
    parameter int DM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic [31:0] wd,
    input  logic        RegDst,
    input  logic        RegWrite,
    input  logic        ALUSrc,
    input  logic [2:0]  op,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] imm,
    output logic [25:0] jTarget,
    output logic [31:0] z,
    output logic        zero,
    output logic [31:0] memOut
);

    localparam int AW = $clog2(DM_WORDS);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    logic [31:0]   rf_q [32];
    logic [31:0]   dm_q [DM_WORDS];

    logic [4:0]    ra1, ra2, wa;
    logic          rf_we;
    logic [31:0]   alu_a, alu_b;
    logic [31:0]   alu_z;
    logic [AW-1:0] dm_idx;
    logic          unused_ins;

    assign ra1 = ins[25:21];
    assign ra2 = ins[20:16];
    assign wa  = RegDst ? ins[15:11] : ins[20:16];
    // $0 is never written, so it holds its reset value of zero forever.
    assign rf_we = RegWrite && (wa != 5'd0);

    assign unused_ins = ^ins[31:26];

    // ------------------------------------------------------------------
    // Register file: two combinational reads, one clocked write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[wa] <= wd;
        end
    end

    assign rd1     = rf_q[ra1];
    assign rd2     = rf_q[ra2];
    assign imm     = {{16{ins[15]}}, ins[15:0]};
    assign jTarget = ins[25:0];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign alu_a = rd1;
    assign alu_b = ALUSrc ? imm : rd2;

    always_comb begin
        alu_z = '0;
        case (op)
            OP_AND:  alu_z = alu_a & alu_b;
            OP_OR:   alu_z = alu_a | alu_b;
            OP_ADD:  alu_z = alu_a + alu_b;
            OP_SUB:  alu_z = alu_a - alu_b;
            // Direct signed compare rather than the sign of A-B, so overflow cannot flip it.
            OP_SLT:  alu_z = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_z = '0;
        endcase
    end

    assign z    = alu_z;
    assign zero = (alu_z == 32'h0);

    // ------------------------------------------------------------------
    // Data memory: byte offset and upper address bits dropped, so addresses wrap
    // ------------------------------------------------------------------
    assign dm_idx = z[AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DM_WORDS; i++) dm_q[i] <= '0;
        end else if (MemWrite) begin
            dm_q[dm_idx] <= rd2;
        end
    end

    assign memOut = MemRead ? dm_q[dm_idx] : 32'h0;

endmodule

// File: tb/tb_id_ex_dm_datapath.sv
// Directed bench for id_ex_dm_datapath: reset, ADDI, R-type ops, SLT, load/store,
// address aliasing, back-to-back writes and mid-run reset.
module tb_id_ex_dm_datapath;

    logic        clk;
    logic        rst_n;
    logic [31:0] ins;
    logic [31:0] wd;
    logic        RegDst, RegWrite, ALUSrc, MemRead, MemWrite;
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm, z, memOut;
    logic [25:0] jTarget;
    logic        zero;

    int errors = 0;
    int checks = 0;

    id_ex_dm_datapath #(.DM_WORDS(64)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .wd(wd),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .op(op),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .rd1(rd1), .rd2(rd2), .imm(imm), .jTarget(jTarget),
        .z(z), .zero(zero), .memOut(memOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helper: write val into register r through the rt write path.
    task automatic set_reg(input logic [4:0] r, input logic [31:0] val);
        @(negedge clk);
        ins = {6'h08, 5'd0, r, 16'd0}; RegDst = 1'b0; RegWrite = 1'b1; wd = val;
        MemWrite = 1'b0;
        @(posedge clk); #1;
        RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ins = 32'h00221820; wd = 32'h0; RegDst = 1'b1; RegWrite = 1'b1;
        ALUSrc = 1'b0; op = 3'b010; MemRead = 1'b1; MemWrite = 1'b1;
        @(posedge clk); #1;
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h exp=%h", rd1, 32'h0); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got=%h exp=%h", rd2, 32'h0); end
        checks++; if (z !== 32'h0) begin errors++; $display("FAIL reset_z got=%h exp=%h", z, 32'h0); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", zero); end
        checks++; if (memOut !== 32'h0) begin errors++; $display("FAIL reset_memOut got=%h exp=%h", memOut, 32'h0); end
        checks++; if (imm !== 32'h00001820) begin errors++; $display("FAIL reset_imm got=%h exp=%h", imm, 32'h00001820); end
        checks++; if (jTarget !== 26'h0221820) begin errors++; $display("FAIL reset_jtarget got=%h exp=%h", jTarget, 26'h0221820); end
        @(negedge clk);
        RegWrite = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        @(negedge clk);
        ins = 32'h20090005; ALUSrc = 1'b1; op = 3'b010; RegDst = 1'b0; RegWrite = 1'b1; wd = 32'd5;
        #1;
        checks++; if (imm !== 32'd5) begin errors++; $display("FAIL addi_imm got=%h exp=%h", imm, 32'd5); end
        checks++; if (z !== 32'd5) begin errors++; $display("FAIL addi_z got=%h exp=%h", z, 32'd5); end
        @(posedge clk); #1;
        RegWrite = 1'b0;
        ins = 32'h01200000; #1;
        checks++; if (rd1 !== 32'd5) begin errors++; $display("FAIL addi_r9 got=%h exp=%h", rd1, 32'd5); end
        ins = 32'h2009FFFF; #1;
        checks++; if (imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm_neg got=%h exp=%h", imm, 32'hFFFFFFFF); end
        checks++; if (z !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_z_neg got=%h exp=%h", z, 32'hFFFFFFFF); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL addi_zero_neg got=%b exp=0", zero); end
    endtask

    task automatic test_rtype();
        set_reg(5'd1, 32'h0F);
        set_reg(5'd2, 32'hF0);
        @(negedge clk);
        ins = 32'h00221820; ALUSrc = 1'b0; RegDst = 1'b1; RegWrite = 1'b0;
        op = 3'b010; #1;
        checks++; if (z !== 32'hFF) begin errors++; $display("FAIL rt_add got=%h exp=%h", z, 32'hFF); end
        op = 3'b001; #1;
        checks++; if (z !== 32'hFF) begin errors++; $display("FAIL rt_or got=%h exp=%h", z, 32'hFF); end
        op = 3'b000; #1;
        checks++; if (z !== 32'h0) begin errors++; $display("FAIL rt_and got=%h exp=%h", z, 32'h0); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rt_and_zero got=%b exp=1", zero); end
        op = 3'b110; #1;
        checks++; if (z !== 32'hFFFFFF1F) begin errors++; $display("FAIL rt_sub got=%h exp=%h", z, 32'hFFFFFF1F); end
        op = 3'b011; #1;
        checks++; if (z !== 32'h0) begin errors++; $display("FAIL rt_undef_op got=%h exp=%h", z, 32'h0); end

        set_reg(5'd1, 32'hFFFFFFFF);
        set_reg(5'd2, 32'h1);
        @(negedge clk); ins = 32'h00221820; op = 3'b111; #1;
        checks++; if (z !== 32'h1) begin errors++; $display("FAIL slt_neg got=%h exp=%h", z, 32'h1); end
        set_reg(5'd1, 32'h80000000);
        @(negedge clk); ins = 32'h00221820; op = 3'b111; #1;
        checks++; if (z !== 32'h1) begin errors++; $display("FAIL slt_ovf_lt got=%h exp=%h", z, 32'h1); end
        set_reg(5'd1, 32'h7FFFFFFF);
        set_reg(5'd2, 32'hFFFFFFFF);
        @(negedge clk); ins = 32'h00221820; op = 3'b111; #1;
        checks++; if (z !== 32'h0) begin errors++; $display("FAIL slt_ovf_ge got=%h exp=%h", z, 32'h0); end

        // rd write to $3 while reading $3 on rs: old value before the edge, new after
        @(negedge clk);
        ins = 32'h00621820; RegDst = 1'b1; RegWrite = 1'b1; wd = 32'h123; #1;
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rdw_before got=%h exp=%h", rd1, 32'h0); end
        @(posedge clk); #1;
        RegWrite = 1'b0; #1;
        checks++; if (rd1 !== 32'h123) begin errors++; $display("FAIL rdw_after got=%h exp=%h", rd1, 32'h123); end
        checks++; if (rd2 !== 32'hFFFFFFFF) begin errors++; $display("FAIL rt_unchanged got=%h exp=%h", rd2, 32'hFFFFFFFF); end

        @(negedge clk);
        ins = 32'h00220000; RegDst = 1'b1; RegWrite = 1'b1; wd = 32'hFFFF;
        @(posedge clk); #1;
        RegWrite = 1'b0; ins = 32'h00000000; #1;
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL r0_write got=%h exp=%h", rd1, 32'h0); end
    endtask

    task automatic test_store_load();
        set_reg(5'd1, 32'd8);
        set_reg(5'd2, 32'hDEADBEEF);
        @(negedge clk);
        ins = 32'hAC220004; ALUSrc = 1'b1; op = 3'b010; MemWrite = 1'b1; MemRead = 1'b1; #1;
        checks++; if (memOut !== 32'h0) begin errors++; $display("FAIL sw_old_word got=%h exp=%h", memOut, 32'h0); end
        @(posedge clk); #1;
        MemWrite = 1'b0;
        ins = 32'h8C230004; MemRead = 1'b1; #1;
        checks++; if (z !== 32'd12) begin errors++; $display("FAIL lw_addr got=%h exp=%h", z, 32'd12); end
        checks++; if (memOut !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=%h", memOut, 32'hDEADBEEF); end
        MemRead = 1'b0; #1;
        checks++; if (memOut !== 32'h0) begin errors++; $display("FAIL lw_noread got=%h exp=%h", memOut, 32'h0); end
    endtask

    task automatic test_alias();
        set_reg(5'd1, 32'd264);
        @(negedge clk); ins = 32'h8C230004; ALUSrc = 1'b1; op = 3'b010; MemRead = 1'b1; #1;
        checks++; if (memOut !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_wrap got=%h exp=%h", memOut, 32'hDEADBEEF); end
        set_reg(5'd1, 32'd9);
        @(negedge clk); ins = 32'h8C230004; MemRead = 1'b1; #1;
        checks++; if (memOut !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_byteoff got=%h exp=%h", memOut, 32'hDEADBEEF); end
        set_reg(5'd1, 32'd12);
        @(negedge clk); ins = 32'h8C230004; MemRead = 1'b1; #1;
        checks++; if (memOut !== 32'h0) begin errors++; $display("FAIL alias_word4 got=%h exp=%h", memOut, 32'h0); end
    endtask

    task automatic test_back_to_back();
        set_reg(5'd1, 32'd8);
        // Edge 1: store $2 (DEADBEEF) to word 5 and overwrite $2; edge 2 stores the new $2 to word 6
        @(negedge clk);
        ins = 32'hAC22000C; ALUSrc = 1'b1; op = 3'b010; MemWrite = 1'b1; MemRead = 1'b0;
        RegDst = 1'b0; RegWrite = 1'b1; wd = 32'h5555;
        @(posedge clk); #1;
        RegWrite = 1'b0; ins = 32'hAC220010;
        @(posedge clk); #1;
        MemWrite = 1'b0; MemRead = 1'b1;
        ins = 32'h8C23000C; #1;
        checks++; if (memOut !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_word5 got=%h exp=%h", memOut, 32'hDEADBEEF); end
        ins = 32'h8C230010; #1;
        checks++; if (memOut !== 32'h5555) begin errors++; $display("FAIL b2b_word6 got=%h exp=%h", memOut, 32'h5555); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        ins = 32'h8C23000C; ALUSrc = 1'b1; op = 3'b010; MemRead = 1'b1; #1;
        rst_n = 1'b0; #1;
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL mid_rst_rd1 got=%h exp=%h", rd1, 32'h0); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL mid_rst_rd2 got=%h exp=%h", rd2, 32'h0); end
        checks++; if (memOut !== 32'h0) begin errors++; $display("FAIL mid_rst_mem got=%h exp=%h", memOut, 32'h0); end
        // Writes held off across an edge while reset is low
        ins = 32'h20A50000; RegDst = 1'b0; RegWrite = 1'b1; wd = 32'h77;
        @(posedge clk); #1;
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rst_blocks_write got=%h exp=%h", rd1, 32'h0); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rst_release got=%h exp=%h", rd1, 32'h0); end
        @(posedge clk); #1;
        RegWrite = 1'b0; #1;
        checks++; if (rd1 !== 32'h77) begin errors++; $display("FAIL write_resume got=%h exp=%h", rd1, 32'h77); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_store_load();
        test_alias();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_dm_datapath.md
# id_ex_dm_datapath

Combined decode / execute / data-memory slice of the single-cycle MIPS-style datapath: a 32×32 register file with immediate and jump-target extraction, a 32-bit ALU with operand-select mux, and a word-addressed data memory. Instruction fetch, control decode and the write-back mux sit outside this block. The external write-back value returns on `wd` for register-file writes.

## Interface
- `DM_WORDS`, 64: data-memory depth in 32-bit words (power of two).
- `clk` in 1: single clock; all storage updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ins` in 32: current instruction word.
- `wd` in 32: register-file write data (write-back value).
- `RegDst` in 1: write-register select; 1 = `ins[15:11]` (rd), 0 = `ins[20:16]` (rt).
- `RegWrite` in 1: register-file write enable.
- `ALUSrc` in 1: ALU B operand; 1 = `imm`, 0 = `rd2`.
- `op` in 3: ALU operation.
- `MemRead` in 1: data-memory read enable.
- `MemWrite` in 1: data-memory write enable.
- `rd1` out 32: register[`ins[25:21]`].
- `rd2` out 32: register[`ins[20:16]`].
- `imm` out 32: sign-extended `ins[15:0]`.
- `jTarget` out 26: `ins[25:0]`.
- `z` out 32: ALU result, also the data-memory byte address.
- `zero` out 1: 1 when `z == 0`.
- `memOut` out 32: data-memory read data.

## Operation
- Register file:
  - 32 × 32 bits.
  - Two combinational read ports.
  - Register 0 always reads 0; writes to register 0 are discarded.
- Register write: on rising `clk` when `RegWrite` = 1, `wd` goes to the register selected by `RegDst`.
- `imm = {{16{ins[15]}}, ins[15:0]}`; `jTarget = ins[25:0]`. Both are purely combinational.
- ALU operands: A = `rd1`; B = `ALUSrc ? imm : rd2`.
- ALU ops:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB (A−B)
  - 111 SLT: signed A<B gives 1, else 0; the compare is correct under overflow.
  - All other codes give `z` = 0.
- ADD and SUB wrap modulo 2^32; no overflow flag.
- `zero = (z == 32'h0)`.
- Data memory:
  - `DM_WORDS` words, indexed by `z[log2(DM_WORDS)+1:2]`.
  - `z[1:0]` is ignored.
  - Higher address bits are ignored, so addresses alias (wrap).
- Memory write: on rising `clk` when `MemWrite` = 1, `rd2` goes to the indexed word.
- Memory read: `memOut` = indexed word when `MemRead` = 1, else 0. The read is combinational.
- `MemRead` and `MemWrite` both 1: the write occurs at the edge, and `memOut` shows the old word until that edge.

## Timing
- All outputs are combinational from `ins`, the control inputs and the stored state; there is no output latency.
- Register-file and memory writes take effect at the rising `clk` edge and are visible on reads immediately after.
- Read-during-write to the same register or word in the same cycle returns the old value before the edge and the new value after it. There is no bypass.
- `rst_n` low, asynchronously:
  - All 32 registers and all `DM_WORDS` memory words clear to 0.
  - With all state 0, outputs are: `rd1` = `rd2` = 0, `memOut` = 0, and `z`/`zero` follow the ALU on zero operands.
- While `rst_n` is low, writes are blocked.
- Writes resume at the first rising edge after `rst_n` deasserts.
- Reset asserted mid-cycle aborts any pending write.

## Test plan
- **Reset:** assert `rst_n` = 0 with `ins` = 0x00221820 → `rd1` = `rd2` = 0; `z` = 0 and `zero` = 1 with `op` = 010, `ALUSrc` = 0.
- **ADDI path:**
  - Stimulus: `ins` = 0x20090005 (`$9 = $0 + 5`), `ALUSrc` = 1, `op` = 010, `RegDst` = 0, `RegWrite` = 1, `wd` = `z`, then one clock edge.
  - Required: `imm` = 5, `z` = 5, and `$9` = 5 after the edge.
  - Then `ins` = 0x2009FFFF gives `imm` = 0xFFFFFFFF and `z` = 0xFFFFFFFF.
- **R-type ops:**
  - Setup: `$1` = 0x0F, `$2` = 0xF0.
  - With `ins` = 0x00221820 (`RegDst` = 1, writes `$3`): `op` 010 gives `z` = 0xFF, 001 gives 0xFF, 000 gives 0x00 with `zero` = 1, 110 gives 0xFFFFFF1F.
  - SLT 111 with `$1` = −1, `$2` = 1 gives `z` = 1.
  - Writes to `$0` leave it reading 0.
- **Store/load:**
  - Setup: `$1` = 8, `$2` = 0xDEADBEEF.
  - SW `ins` = 0xAC220004 with `MemWrite` = 1, `ALUSrc` = 1, then one edge.
  - LW `ins` = 0x8C230004 with `MemRead` = 1 → `z` = 12, `memOut` = 0xDEADBEEF.
  - Same address with `MemRead` = 0 → `memOut` = 0.
- **Aliasing and byte offset:** address 12 + 4·`DM_WORDS` reads the same word as 12, and address 13 reads word 3.
- **Mid-run reset:** after loading registers and memory, pulse `rst_n` low between edges → all reads return 0 immediately.
